// File: rtl/inst_rom_loader_if.sv
// Fetch/upload port bundle for the instruction ROM loader.
// Latency: wiring only.
// Backpressure: none; rx_valid is a fire-and-forget strobe, up_start/up_end are 1-cycle pulses.
//
// Ports (master = CPU/UART side, slave = loader):
//   rom_adr_i  fetch word address        instr_o     instruction to fetch
//   up_start   enter/restart LOAD pulse  up_end      finish LOAD pulse
//   rx_valid   byte strobe               rx_byte     received byte
//   cpu_hold_o CPU stall while loading   cpu_rst_o   1-cycle CPU reset after load
//   word_cnt_o words written             overflow_o  sticky dropped-word flag
interface inst_rom_loader_if #(
  parameter int ADDR_W = 14
) ();
  logic [ADDR_W-1:0] rom_adr_i;
  logic [31:0]       instr_o;
  logic              up_start;
  logic              up_end;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic              cpu_hold_o;
  logic              cpu_rst_o;
  logic [ADDR_W:0]   word_cnt_o;
  logic              overflow_o;

  modport master (
    output rom_adr_i, up_start, up_end, rx_valid, rx_byte,
    input  instr_o, cpu_hold_o, cpu_rst_o, word_cnt_o, overflow_o
  );

  modport slave (
    input  rom_adr_i, up_start, up_end, rx_valid, rx_byte,
    output instr_o, cpu_hold_o, cpu_rst_o, word_cnt_o, overflow_o
  );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM with UART-fed reprogramming: RUN serves fetch, LOAD packs bytes into words from address 0.
// Latency: instr_o is mem[rom_adr_i] one clock later; a 4th byte is written on the posedge that takes it.
// Backpressure: none toward the UART (bytes past a full memory are dropped and flagged); CPU is held via cpu_hold_o.
//
// Ports: clock, reset (async, active-high), bus (inst_rom_loader_if.slave):
//   fetch: rom_adr_i -> instr_o; upload: up_start, up_end, rx_valid, rx_byte;
//   status: cpu_hold_o, cpu_rst_o, word_cnt_o, overflow_o.
module inst_rom_loader #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 100000
) (
  input  logic               clock,
  input  logic               reset,
  inst_rom_loader_if.slave   bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_LOAD, S_FLUSH, S_RST} state_t;

  state_t            state, state_n;
  logic [31:0]       mem [DEPTH];
  // wr_ptr has one extra bit so it can reach DEPTH; it doubles as the word count.
  logic [ADDR_W:0]   wr_ptr;
  logic [1:0]        byte_idx;
  logic [31:0]       word_buf;
  logic [IDLE_W-1:0] idle_cnt;
  logic              overflow;
  logic [31:0]       instr_q;

  logic              full;
  logic              restart;
  logic              rx_take;
  logic              finish;
  logic [31:0]       packed_word;
  logic              wr_en;
  logic [31:0]       wr_dat;

  assign full = wr_ptr[ADDR_W];

  // Upload control decode; up_start has priority over same-cycle up_end/rx_valid.
  always_comb begin
    restart     = bus.up_start && (state == S_RUN || state == S_LOAD);
    rx_take     = (state == S_LOAD) && bus.rx_valid && !bus.up_start;
    finish      = (state == S_LOAD) && !bus.up_start &&
                  (bus.up_end || idle_cnt == IDLE_LAST);
    // word_buf upper bytes are kept zero, so the partial word is already zero-padded.
    packed_word = word_buf;
    case (byte_idx)
      2'd0:    packed_word[7:0]   = bus.rx_byte;
      2'd1:    packed_word[15:8]  = bus.rx_byte;
      2'd2:    packed_word[23:16] = bus.rx_byte;
      default: packed_word[31:24] = bus.rx_byte;
    endcase
    wr_en  = 1'b0;
    wr_dat = packed_word;
    if (rx_take && byte_idx == 2'd3 && !full) begin
      wr_en = 1'b1;
    end
    if (state == S_FLUSH && byte_idx != 2'd0 && !full) begin
      wr_en  = 1'b1;
      wr_dat = word_buf;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_RUN:   if (bus.up_start) state_n = S_LOAD;
      S_LOAD:  if (finish) state_n = S_FLUSH;
      S_FLUSH: state_n = S_RST;
      S_RST:   state_n = S_RUN;
      default: state_n = S_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_n;
  end

  // Memory has no reset so an interrupted upload keeps the words it already wrote.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= wr_dat;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q  <= '0;
      wr_ptr   <= '0;
      byte_idx <= '0;
      word_buf <= '0;
      idle_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      // Keyed on the next state so the nop appears with the hold and the
      // first RUN cycle after RST already carries a real instruction.
      instr_q <= (state_n == S_RUN) ? mem[bus.rom_adr_i] : '0;
      if (restart) begin
        wr_ptr   <= '0;
        byte_idx <= '0;
        word_buf <= '0;
        idle_cnt <= '0;
        overflow <= 1'b0;
      end else if (state == S_LOAD) begin
        idle_cnt <= bus.rx_valid ? '0 : idle_cnt + IDLE_W'(1);
        if (rx_take) begin
          if (byte_idx == 2'd3) begin
            byte_idx <= '0;
            word_buf <= '0;
            if (full) overflow <= 1'b1;
            else      wr_ptr   <= wr_ptr + (ADDR_W+1)'(1);
          end else begin
            byte_idx <= byte_idx + 2'd1;
            word_buf <= packed_word;
          end
        end
      end else if (state == S_FLUSH) begin
        if (byte_idx != 2'd0) begin
          if (full) overflow <= 1'b1;
          else      wr_ptr   <= wr_ptr + (ADDR_W+1)'(1);
        end
        byte_idx <= '0;
        word_buf <= '0;
        idle_cnt <= '0;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  assign bus.instr_o    = instr_q;
  assign bus.cpu_hold_o = (state != S_RUN);
  assign bus.cpu_rst_o  = (state == S_RST);
  assign bus.word_cnt_o = wr_ptr;
  assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader with a 16-word memory and a 16-clock idle timeout.
// Inputs change on the negedge; outputs are sampled on the negedge before inputs move.
// No flow control; each scenario task checks its own expected values inline.
module tb_inst_rom_loader;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  inst_rom_loader_if #(.ADDR_W(4)) bus ();

  inst_rom_loader #(.ADDR_W(4), .TIMEOUT(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    @(negedge clock);
    bus.rx_valid = 1'b0;
    bus.rx_byte  = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_start();
    bus.up_start = 1'b1;
    @(negedge clock);
    bus.up_start = 1'b0;
  endtask

  // up_end, then through FLUSH and RST back to RUN.
  task automatic end_upload();
    bus.up_end = 1'b1;
    @(negedge clock);
    bus.up_end = 1'b0;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic read_word(input logic [3:0] addr, output logic [31:0] data);
    bus.rom_adr_i = addr;
    @(negedge clock);
    data = bus.instr_o;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", bus.instr_o); end
    n_checks++; if (bus.cpu_hold_o !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", bus.cpu_hold_o); end
    n_checks++; if (bus.cpu_rst_o !== 1'b0) begin n_fail++; $display("FAIL reset_cpurst: got %b want 0", bus.cpu_rst_o); end
    n_checks++; if (bus.word_cnt_o !== 5'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.word_cnt_o); end
    n_checks++; if (bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", bus.overflow_o); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_read_latency();
    logic [31:0] d;
    pulse_start();
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
    send_word(32'h2010_0005);
    end_upload();
    bus.rom_adr_i = 4'd3;
    @(negedge clock);
    n_checks++; if (bus.instr_o !== 32'h2010_0005) begin n_fail++; $display("FAIL read_mem3: got %h want 20100005", bus.instr_o); end
    bus.rom_adr_i = 4'd2;
    #2;
    n_checks++; if (bus.instr_o !== 32'h2010_0005) begin n_fail++; $display("FAIL read_latency_hold: got %h want 20100005", bus.instr_o); end
    @(negedge clock);
    d = bus.instr_o;
    n_checks++; if (d !== 32'h3333_3333) begin n_fail++; $display("FAIL read_mem2: got %h want 33333333", d); end
  endtask

  task automatic test_basic_load();
    logic [31:0] d;
    pulse_start();
    n_checks++; if (bus.cpu_hold_o !== 1'b1) begin n_fail++; $display("FAIL load_hold: got %b want 1", bus.cpu_hold_o); end
    n_checks++; if (bus.instr_o !== 32'h0) begin n_fail++; $display("FAIL load_nop: got %h want 0", bus.instr_o); end
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h10); send_byte(8'h20);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    bus.up_end = 1'b1;
    @(negedge clock);
    bus.up_end = 1'b0;
    n_checks++; if ({bus.cpu_hold_o, bus.cpu_rst_o} !== 2'b10) begin n_fail++; $display("FAIL flush_hold_rst: got %b want 10", {bus.cpu_hold_o, bus.cpu_rst_o}); end
    @(negedge clock);
    n_checks++; if ({bus.cpu_hold_o, bus.cpu_rst_o} !== 2'b11) begin n_fail++; $display("FAIL rst_hold_rst: got %b want 11", {bus.cpu_hold_o, bus.cpu_rst_o}); end
    @(negedge clock);
    n_checks++; if ({bus.cpu_hold_o, bus.cpu_rst_o} !== 2'b00) begin n_fail++; $display("FAIL run_hold_rst: got %b want 00", {bus.cpu_hold_o, bus.cpu_rst_o}); end
    n_checks++; if (bus.word_cnt_o !== 5'd2) begin n_fail++; $display("FAIL basic_cnt: got %0d want 2", bus.word_cnt_o); end
    read_word(4'd0, d);
    n_checks++; if (d !== 32'h2010_0005) begin n_fail++; $display("FAIL basic_mem0: got %h want 20100005", d); end
    read_word(4'd1, d);
    n_checks++; if (d !== 32'hDDCC_BBAA) begin n_fail++; $display("FAIL basic_mem1: got %h want DDCCBBAA", d); end
    // rx_valid and up_end are ignored in RUN.
    send_byte(8'h77);
    bus.up_end = 1'b1;
    @(negedge clock);
    bus.up_end = 1'b0;
    n_checks++; if ({bus.cpu_hold_o, bus.word_cnt_o} !== {1'b0, 5'd2}) begin n_fail++; $display("FAIL run_ignore: got hold=%b cnt=%0d want hold=0 cnt=2", bus.cpu_hold_o, bus.word_cnt_o); end
  endtask

  task automatic test_partial();
    logic [31:0] d;
    pulse_start();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    end_upload();
    n_checks++; if (bus.word_cnt_o !== 5'd1) begin n_fail++; $display("FAIL partial_cnt: got %0d want 1", bus.word_cnt_o); end
    n_checks++; if (bus.overflow_o !== 1'b0) begin n_fail++; $display("FAIL partial_ovf: got %b want 0", bus.overflow_o); end
    read_word(4'd0, d);
    n_checks++; if (d !== 32'h0033_2211) begin n_fail++; $display("FAIL partial_mem0: got %h want 00332211", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    pulse_start();
    for (int i = 0; i < 68; i++) send_byte(8'(i));
    end_upload();
    n_checks++; if (bus.word_cnt_o !== 5'd16) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 16", bus.word_cnt_o); end
    n_checks++; if (bus.overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", bus.overflow_o); end
    read_word(4'd15, d);
    n_checks++; if (d !== 32'h3F3E_3D3C) begin n_fail++; $display("FAIL ovf_mem15: got %h want 3F3E3D3C", d); end
    read_word(4'd0, d);
    n_checks++; if (d !== 32'h0302_0100) begin n_fail++; $display("FAIL ovf_mem0: got %h want 03020100", d); end
    pulse_start();
    n_checks++; if ({bus.overflow_o, bus.word_cnt_o} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL ovf_clear: got ovf=%b cnt=%0d want ovf=0 cnt=0", bus.overflow_o, bus.word_cnt_o); end
    end_upload();
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    int seen;
    pulse_start();
    send_word(32'hCAFE_F00D);
    seen = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (bus.cpu_rst_o === 1'b1) begin
        seen = i;
        break;
      end
    end
    n_checks++; if (seen !== 17) begin n_fail++; $display("FAIL timeout_rst_cycle: got %0d want 17", seen); end
    @(negedge clock);
    n_checks++; if ({bus.cpu_hold_o, bus.cpu_rst_o, bus.word_cnt_o} !== {2'b00, 5'd1}) begin n_fail++; $display("FAIL timeout_state: got hold/rst=%b%b cnt=%0d want 00 cnt=1", bus.cpu_hold_o, bus.cpu_rst_o, bus.word_cnt_o); end
    read_word(4'd0, d);
    n_checks++; if (d !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL timeout_mem0: got %h want CAFEF00D", d); end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] d;
    int rst_seen;
    pulse_start();
    for (int i = 1; i <= 6; i++) send_byte(8'(i));
    reset = 1'b1;
    #1;
    n_checks++; if ({bus.cpu_hold_o, bus.cpu_rst_o, bus.overflow_o} !== 3'b000) begin n_fail++; $display("FAIL midrst_flags: got %b want 000", {bus.cpu_hold_o, bus.cpu_rst_o, bus.overflow_o}); end
    n_checks++; if ({bus.word_cnt_o, bus.instr_o} !== 37'h0) begin n_fail++; $display("FAIL midrst_cnt_instr: got cnt=%0d instr=%h want 0", bus.word_cnt_o, bus.instr_o); end
    @(negedge clock);
    reset = 1'b0;
    rst_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.cpu_rst_o === 1'b1) rst_seen++;
    end
    n_checks++; if (rst_seen !== 0) begin n_fail++; $display("FAIL midrst_no_cpurst: got %0d pulses want 0", rst_seen); end
    read_word(4'd0, d);
    n_checks++; if (d !== 32'h0403_0201) begin n_fail++; $display("FAIL midrst_mem0: got %h want 04030201", d); end
    read_word(4'd1, d);
    n_checks++; if (d !== 32'h0706_0504) begin n_fail++; $display("FAIL midrst_mem1: got %h want 07060504", d); end
  endtask

  task automatic test_start_end_same_cycle();
    logic [31:0] d;
    pulse_start();
    send_word(32'h0BAD_0BAD);
    send_byte(8'h99);
    bus.up_start = 1'b1;
    bus.up_end   = 1'b1;
    bus.rx_valid = 1'b1;
    bus.rx_byte  = 8'h55;
    @(negedge clock);
    bus.up_start = 1'b0;
    bus.up_end   = 1'b0;
    bus.rx_valid = 1'b0;
    n_checks++; if ({bus.cpu_hold_o, bus.word_cnt_o} !== {1'b1, 5'd0}) begin n_fail++; $display("FAIL restart_state: got hold=%b cnt=%0d want hold=1 cnt=0", bus.cpu_hold_o, bus.word_cnt_o); end
    send_word(32'h1234_5678);
    end_upload();
    n_checks++; if (bus.word_cnt_o !== 5'd1) begin n_fail++; $display("FAIL restart_cnt: got %0d want 1", bus.word_cnt_o); end
    read_word(4'd0, d);
    n_checks++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL restart_mem0: got %h want 12345678", d); end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.rom_adr_i = '0;
    bus.up_start  = 1'b0;
    bus.up_end    = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    test_reset();
    test_read_latency();
    test_basic_load();
    test_partial();
    test_overflow();
    test_timeout();
    test_reset_mid_load();
    test_start_end_same_cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
